// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : RISC-V instruction fetch with one outstanding imem request,
//            2-entry (instr, pc) queue to decode, redirect and halt handling.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    input  logic        halt,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    logic [0:0]  r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_pc;
    logic        r_pend;
    logic        r_discard;
    logic        r_halted;
    logic        r_head;
    logic [1:0]  r_count;
    logic [31:0] r_q_instr [2];
    logic [31:0] r_q_pc    [2];

    logic        w_run;
    logic        w_drain;
    logic        w_redir;
    logic        w_halt_take;
    logic        w_resp;
    logic        w_fill;
    logic [2:0]  w_occ;
    logic        w_issue;
    logic        w_grant;
    logic        w_tail;
    logic        w_unused_pc_lsb;

    assign w_run       = (r_state == ST_RUN);
    assign w_drain     = if_valid & if_ready;
    assign w_redir     = w_run & redirect;
    assign w_halt_take = w_run & w_drain & halt & ~redirect;
    assign w_resp      = imem_rvalid & r_pend;
    // Responses landing in a redirect or halt cycle belong to a dead path.
    assign w_fill      = w_resp & ~r_discard & w_run & ~redirect & ~w_halt_take;
    assign w_occ       = {1'b0, r_count} - {2'b00, w_drain} + {2'b00, r_pend};
    assign w_issue     = rst_n & w_run & ~redirect & ~(w_drain & halt)
                       & (~r_pend | imem_rvalid) & (w_occ < 3'd2);
    assign w_grant     = w_issue & imem_gnt;
    assign w_tail      = r_head ^ r_count[0];

    assign w_unused_pc_lsb = ^redirect_pc[1:0];

    assign imem_req  = w_issue;
    assign imem_addr = r_fetch_pc;
    assign if_valid  = (r_count != 2'd0);
    assign if_instr  = r_q_instr[r_head];
    assign if_pc     = r_q_pc[r_head];
    assign halted    = r_halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_pend     <= 1'b0;
            r_discard  <= 1'b0;
            r_halted   <= 1'b0;
            r_head     <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            if (w_grant) begin
                r_pend     <= 1'b1;
                r_req_pc   <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end else if (w_resp) begin
                r_pend <= 1'b0;
            end

            // A back-to-back grant must not inherit the discard of the old response.
            if (w_resp) begin
                r_discard <= 1'b0;
            end

            if (w_redir) begin
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
                r_count    <= 2'd0;
                if (r_pend & ~imem_rvalid) begin
                    r_discard <= 1'b1;
                end
            end else if (w_halt_take) begin
                r_state  <= ST_HALTED;
                r_halted <= 1'b1;
                r_count  <= 2'd0;
                if (r_pend & ~imem_rvalid) begin
                    r_discard <= 1'b1;
                end
            end else begin
                case ({w_fill, w_drain})
                    2'b10: r_count <= r_count + 2'd1;
                    2'b01: begin
                        r_count <= r_count - 2'd1;
                        r_head  <= ~r_head;
                    end
                    2'b11: r_head <= ~r_head;
                    default: ;
                endcase
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q_instr[gi] <= 32'd0;
                    r_q_pc[gi]    <= 32'd0;
                end else if (w_fill && (w_tail == gi[0])) begin
                    r_q_instr[gi] <= imem_rdata;
                    r_q_pc[gi]    <= r_req_pc;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// Directed bench for fetch_stage: in-order memory model with variable latency,
// expected-PC scoreboard popped on every decode handshake.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC    = 32'h0000_0100;
    localparam logic [31:0] HALT_ADDR = 32'h0000_4008;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'd0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        halt;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halted;

    logic        gnt_en;
    int          lat;
    int          checks   = 0;
    int          failures = 0;
    int          hs_cnt   = 0;
    int          gaps;

    typedef struct {
        logic [31:0] addr;
        int          age;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] exp_q[$];

    assign imem_gnt = gnt_en;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_ready   (if_ready),
        .halt       (halt),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == HALT_ADDR) return 32'h0010_0073;
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory: respond to the oldest grant once it is lat cycles old, then sample new grant.
    always @(negedge clk) begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        foreach (mq[i]) mq[i].age = mq[i].age + 1;
        if (mq.size() > 0 && mq[0].age >= lat) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_f(mq[0].addr);
            void'(mq.pop_front());
        end
        #1;
        if (rst_n && imem_req && imem_gnt) begin
            mq.push_back('{addr: imem_addr, age: 0});
        end
    end

    // Scoreboard: every handshake pops one expected PC.
    always @(negedge clk) begin
        logic [31:0] e;
        #3;
        if (rst_n && if_valid && if_ready) begin
            hs_cnt++;
            chk("exp_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_pc", if_pc, e);
                chk("out_instr", if_instr, mem_f(e));
            end
        end
    end

    task automatic run_ready(input int n, input int budget);
        int goal;
        int cyc;
        goal = hs_cnt + n;
        cyc  = 0;
        while (hs_cnt < goal && cyc < budget) begin
            @(negedge clk);
            if_ready = 1'b1;
            #4;
            cyc++;
        end
        chk("handshake_count", 32'(hs_cnt), 32'(goal));
        @(negedge clk);
        if_ready = 1'b0;
    endtask

    task automatic push_pcs(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; if_ready = 1'b0; halt = 1'b0; redirect = 1'b0;
        redirect_pc = 32'd0; gnt_en = 1'b1; lat = 1;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);

        // Streaming from reset
        @(negedge clk);
        rst_n = 1'b1; if_ready = 1'b1;
        push_pcs(RST_PC, 8);
        #2;
        chk("c1_req", 32'(imem_req), 32'd1);
        chk("c1_addr", imem_addr, 32'h100);
        @(negedge clk); #2;
        chk("c2_addr", imem_addr, 32'h104);
        @(negedge clk); #2;
        chk("c3_addr", imem_addr, 32'h108);
        chk("c3_valid", 32'(if_valid), 32'd1);
        gaps = 0;
        repeat (7) begin
            @(negedge clk); #2;
            if (!if_valid) gaps++;
        end
        chk("stream_gaps", 32'(gaps), 32'd0);
        @(negedge clk);
        if_ready = 1'b0;
        #2;
        chk("stream_hs", 32'(hs_cnt), 32'd8);

        // Backpressure: queue saturates, fetch stops
        repeat (5) @(negedge clk);
        #2;
        chk("stall_req", 32'(imem_req), 32'd0);
        chk("stall_valid", 32'(if_valid), 32'd1);
        chk("stall_addr", imem_addr, 32'h128);
        push_pcs(32'h120, 6);
        run_ready(6, 30);

        // Redirect with a 2-cycle response outstanding
        repeat (4) @(negedge clk);
        lat = 2;
        push_pcs(32'h138, 1);
        run_ready(1, 10);
        redirect = 1'b1; redirect_pc = 32'h0000_2003;
        #2;
        chk("redir_req_withdrawn", 32'(imem_req), 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        #2;
        chk("redir_valid", 32'(if_valid), 32'd0);
        chk("redir_addr", imem_addr, 32'h2000);
        push_pcs(32'h2000, 3);
        run_ready(3, 40);

        // Redirect and halt together: redirect wins
        repeat (4) @(negedge clk);
        lat = 1;
        push_pcs(32'h200C, 1);
        if_ready = 1'b1; halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_3000;
        @(negedge clk);
        if_ready = 1'b0; halt = 1'b0; redirect = 1'b0;
        #2;
        chk("rh_halted", 32'(halted), 32'd0);
        chk("rh_addr", imem_addr, 32'h3000);
        chk("rh_valid", 32'(if_valid), 32'd0);
        push_pcs(32'h3000, 2);
        run_ready(2, 40);

        // Grant withheld: address holds until granted
        @(negedge clk);
        gnt_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_4000;
        @(negedge clk);
        redirect = 1'b0;
        #2;
        chk("nogt_addr1", imem_addr, 32'h4000);
        @(negedge clk); #2;
        chk("nogt_addr2", imem_addr, 32'h4000);
        @(negedge clk);
        gnt_en = 1'b1;
        #2;
        chk("nogt_addr3", imem_addr, 32'h4000);
        chk("nogt_req3", 32'(imem_req), 32'd1);
        @(negedge clk); #2;
        chk("gt_addr_adv", imem_addr, 32'h4004);
        push_pcs(32'h4000, 2);
        run_ready(2, 40);

        // Halt on ecall at 0x4008
        repeat (3) @(negedge clk);
        #2;
        chk("pre_halt_instr", if_instr, 32'h0010_0073);
        chk("pre_halt_addr", imem_addr, 32'h4010);
        @(negedge clk);
        push_pcs(HALT_ADDR, 1);
        if_ready = 1'b1; halt = 1'b1;
        @(negedge clk);
        if_ready = 1'b0; halt = 1'b0;
        #2;
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_valid", 32'(if_valid), 32'd0);
        chk("halt_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h0000_5000;
        @(negedge clk);
        redirect = 1'b0;
        #2;
        chk("halt_redir_req", 32'(imem_req), 32'd0);
        chk("halt_redir_addr", imem_addr, 32'h4010);
        chk("halt_redir_halted", 32'(halted), 32'd1);
        repeat (2) @(negedge clk);
        #2;
        chk("halt_late_req", 32'(imem_req), 32'd0);
        chk("halt_late_valid", 32'(if_valid), 32'd0);

        // Reset mid-stream with a request pending; stale response after release
        @(negedge clk);
        rst_n = 1'b0; lat = 3;
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        chk("mid_pre_valid", 32'(if_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_valid", 32'(if_valid), 32'd0);
        chk("mid_rst_pc", if_pc, 32'd0);
        chk("mid_rst_instr", if_instr, 32'd0);
        chk("mid_rst_addr", imem_addr, RST_PC);
        chk("mid_rst_halted", 32'(halted), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("mid_rel_req", 32'(imem_req), 32'd1);
        chk("mid_rel_addr", imem_addr, RST_PC);
        push_pcs(RST_PC, 3);
        run_ready(3, 60);

        repeat (2) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
